byte_serial_add64: RTL and testbench
====================================

BYTE_SERIAL_ADD64 -- requirements
Module: byte_serial_add64

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter SLICE, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to add the a, b and cin values sampled on the same edge.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 ready  output  1  high when start will be accepted (IDLE or DONE).
REQ-010 busy  output  1  high while slices are being added (RUN).
REQ-011 done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
REQ-012 sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-013 cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: on start=1, capture a, b and cin into operand/carry registers, clear the slice counter, go to RUN.
REQ-016 RUN: each cycle, add slice i (bits SLICE*i+SLICE-1 : SLICE*i) of a_reg, b_reg and carry_reg; write the slice result into an accumulator; load carry_reg with the slice carry; increment i.
REQ-017 RUN: when i = WIDTH/SLICE-1, go to DONE after that slice completes; latch the accumulator into sum and the final carry into cout.
REQ-018 DONE: done=1 for exactly one cycle; start=1 here is accepted as in IDLE (back-to-back), otherwise go to IDLE.
REQ-019 Latency: start sampled at the end of cycle 0; busy=1 in cycles 1..WIDTH/SLICE; done=1 in cycle WIDTH/SLICE+1 (cycle 9 at defaults).
REQ-020 start while in RUN SHALL be ignored; operands, counter and carry are unaffected.
REQ-021 Changes on a, b and cin after capture SHALL NOT affect the result in progress.
REQ-022 sum and cout SHALL hold their last values until the next DONE; they are never partially updated.
REQ-023 Output decode: ready = IDLE or DONE; busy = RUN; done = DONE.
REQ-024 Carry SHALL propagate across every slice boundary, including a chain that runs through all slices.

Reset
REQ-025 rst=1 on any edge forces IDLE, clears the operand, accumulator, carry and counter registers, and sets sum=0 and cout=0; done=0 and busy=0.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse follows and sum keeps its reset value of 0.
REQ-027 rst takes priority over start on the same edge.

Structure
REQ-028 The FSM state encoding and the SLICE/WIDTH defaults SHALL live in a shared adder package.
REQ-029 The per-slice addition SHALL be one instance of the existing RCA_8bit adder (ports sum, cout, a, b, cin); no other sub-modules.
REQ-030 The slice counter SHALL be $clog2(WIDTH/SLICE) bits wide.

Verification
REQ-031 a=7, b=3, cin=0, start pulse -> done in cycle 9, sum=10, cout=0.
REQ-032 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1; the carry ripples through all 8 slices.
REQ-033 a=0x0000_0000_0000_00FF, b=1, cin=0 -> sum=0x100, cout=0; checks the slice-0 to slice-1 carry.
REQ-034 start re-pulsed in cycle 4 with different operands -> ignored; the first result appears in cycle 9 and there is no second done.
REQ-035 rst asserted in cycle 5 of a RUN -> next cycle busy=0, ready=1, sum=0, cout=0; no done pulse.
REQ-036 start held high in the DONE cycle with a=1, b=1 -> the second operation is accepted; its done comes 9 cycles later with sum=2, while the first sum stays stable until then.

Source files
------------

// File: rtl/byte_serial_add64_pkg.sv
// Shared definitions for the byte-serial adder: default geometry and FSM encoding.
package byte_serial_add64_pkg;

   localparam int ADD_WIDTH = 64;
   localparam int ADD_SLICE = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/byte_serial_add64_rca.sv
// 8-bit ripple-carry adder used as the per-slice adder of the serial datapath.
module RCA_8bit (
   output logic [7:0] sum,
   output logic       cout,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin
);

   logic [8:0] c;

   // ripple the carry bit by bit through the slice
   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int k = 0; k < 8; k++) begin
         c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
      end
   end

   assign sum  = a ^ b ^ c[7:0];
   assign cout = c[8];

endmodule

// File: rtl/byte_serial_add64.sv
// Byte-serial WIDTH-bit adder: one SLICE-bit slice per cycle through a single
// ripple-carry slice adder, result latched into sum/cout only when complete.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; ready=1
// ST_RUN  | adding slice idx each cycle; busy=1, start ignored
// ST_DONE | sum/cout just updated; done=1 for this cycle, ready=1
module byte_serial_add64
   import byte_serial_add64_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH,
   parameter int SLICE = ADD_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // the slice adder is a fixed 8-bit RCA, so SLICE is expected to stay 8
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             carry_reg;
   logic [CNT_W-1:0] idx;

   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_sum;
   logic             slice_cout;

   assign slice_a = a_reg[idx*SLICE +: SLICE];
   assign slice_b = b_reg[idx*SLICE +: SLICE];

   RCA_8bit u_rca (
      .sum  (slice_sum),
      .cout (slice_cout),
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg)
   );

   // accumulator with the current slice merged in, so the final slice can go
   // straight into sum on the last RUN edge
   always_comb begin
      acc_nxt                     = acc;
      acc_nxt[idx*SLICE +: SLICE] = slice_sum;
   end

   // sequencing FSM, operand capture, slice accumulation and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  idx       <= '0;
                  state     <= ST_RUN;
                  ready     <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            ST_RUN: begin
               acc       <= acc_nxt;
               carry_reg <= slice_cout;
               idx       <= idx + 1'b1;
               if (idx == LAST) begin
                  sum   <= acc_nxt;
                  cout  <= slice_cout;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serial_add64.sv
// Bench for byte_serial_add64: table vectors, random vectors and hand-written
// multi-cycle sequences; results are checked through an expected-result queue.
module tb_byte_serial_add64;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   byte_serial_add64 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic [W-1:0] esum;
      logic         ecout;
   } vec_t;

   int         nvec = 0;
   int         nerr = 0;
   logic [W:0] sb_q[$];
   logic [W:0] last_res = '0;

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // completed results are popped from the queue and compared at done
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_done: got done=1 with no operation pending, expected done=0");
         end else begin
            logic [W:0] e;
            e = sb_q.pop_front();
            check("result", {cout, sum}, e);
            last_res = e;
         end
      end
   end

   // one full operation starting in a ready cycle; operands are scrambled
   // while it runs and the previous result must stay on sum meanwhile
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                         input logic [W:0] exp);
      int busy_cnt;
      int done_cyc;
      int done_cnt;
      check("ready_before_start", {64'd0, ready}, 65'd1);
      a     = va;
      b     = vb;
      cin   = vcin;
      start = 1'b1;
      sb_q.push_back(exp);
      tick();
      start    = 1'b0;
      busy_cnt = 0;
      done_cyc = 0;
      done_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         cin = 1'($urandom_range(0, 1));
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (c == 5) check("sum_held_during_run", {cout, sum}, last_res);
         tick();
      end
      check("busy_cycles", 65'(busy_cnt), 65'd8);
      check("done_cycle", 65'(done_cyc), 65'd9);
      check("done_pulses", 65'(done_cnt), 65'd1);
   endtask

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cyc;
      int done_cnt;
      bit stable;

      vecs[0] = '{64'd7, 64'd3, 1'b0, 64'd10, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
      vecs[2] = '{64'h0000_0000_0000_00FF, 64'd1, 1'b0, 64'h100, 1'b0};
      vecs[3] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
      vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[7] = '{64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 64'h0100_0100_0100_0100, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      tick();
      tick();
      check("reset_ready", {64'd0, ready}, 65'd1);
      check("reset_busy", {64'd0, busy}, 65'd0);
      check("reset_done", {64'd0, done}, 65'd0);
      check("reset_sum_cout", {cout, sum}, 65'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, {vecs[i].ecout, vecs[i].esum});
      end

      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {64'd0, rc});
      end

      // start re-pulsed mid-run must be ignored
      a     = 64'd5;
      b     = 64'd6;
      cin   = 1'b0;
      start = 1'b1;
      sb_q.push_back(65'd11);
      tick();
      start    = 1'b0;
      done_cyc = 0;
      done_cnt = 0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 4) begin
            a     = 64'd100;
            b     = 64'd200;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         tick();
      end
      check("repulse_done_cycle", 65'(done_cyc), 65'd9);
      check("repulse_done_pulses", 65'(done_cnt), 65'd1);

      // reset in cycle 5 of a run aborts it
      a     = 64'h1234;
      b     = 64'h4321;
      start = 1'b1;
      sb_q.push_back(65'h5555);
      tick();
      start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      rst = 1'b1;
      sb_q.delete();
      last_res = '0;
      tick();
      check("abort_busy", {64'd0, busy}, 65'd0);
      check("abort_ready", {64'd0, ready}, 65'd1);
      check("abort_sum_cout", {cout, sum}, 65'd0);
      rst      = 1'b0;
      done_cnt = 0;
      for (int c = 6; c <= 14; c++) begin
         if (done) done_cnt++;
         tick();
      end
      check("abort_no_done", 65'(done_cnt), 65'd0);
      check("abort_sum_kept", {cout, sum}, 65'd0);

      // reset wins over start on the same edge
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_over_start_busy", {64'd0, busy}, 65'd0);
      tick();
      check("rst_over_start_idle", {64'd0, busy}, 65'd0);

      // back-to-back start in the DONE cycle
      a     = 64'h10;
      b     = 64'h20;
      cin   = 1'b0;
      start = 1'b1;
      sb_q.push_back(65'h30);
      tick();
      start = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      check("b2b_first_done", {64'd0, done}, 65'd1);
      a     = 64'd1;
      b     = 64'd1;
      cin   = 1'b0;
      start = 1'b1;
      sb_q.push_back(65'd2);
      tick();
      start = 1'b0;
      check("b2b_second_busy", {64'd0, busy}, 65'd1);
      stable   = 1'b1;
      done_cyc = 0;
      for (int c = 10; c <= 22; c++) begin
         if (done && done_cyc == 0) done_cyc = c;
         if (done_cyc == 0 && {cout, sum} !== 65'h30) stable = 1'b0;
         tick();
      end
      check("b2b_first_sum_stable", {64'd0, stable}, 65'd1);
      check("b2b_second_done_cycle", 65'(done_cyc), 65'd18);
      check("queue_drained", 65'(sb_q.size()), 65'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
